// File: rtl/bus_master_if_if.sv
// Core-side and shared-bus signals of the bus master, bundled with modports
// for the master itself and for whatever environment drives it.
interface bus_master_if_if #(
  parameter int ADDR_WIDTH     = 30,
  parameter int DATA_BUS_WIDTH = 32
);
  logic                      req_i;
  logic                      rw_i;
  logic [ADDR_WIDTH-1:0]     addr_i;
  logic [DATA_BUS_WIDTH-1:0] wr_data_i;
  logic                      ready_o;
  logic                      done_o;
  logic                      err_o;
  logic [DATA_BUS_WIDTH-1:0] rd_data_o;

  logic                      bus_req_o;
  logic                      bus_grnt_i;
  logic                      bus_as_o;
  logic                      bus_rw_o;
  logic [ADDR_WIDTH-1:0]     bus_addr_o;
  logic [DATA_BUS_WIDTH-1:0] bus_wr_data_o;
  logic [DATA_BUS_WIDTH-1:0] bus_rd_data_i;
  logic                      bus_rdy_i;

  modport master (
    input  req_i, rw_i, addr_i, wr_data_i,
    input  bus_grnt_i, bus_rd_data_i, bus_rdy_i,
    output ready_o, done_o, err_o, rd_data_o,
    output bus_req_o, bus_as_o, bus_rw_o, bus_addr_o, bus_wr_data_o
  );

  modport slave (
    output req_i, rw_i, addr_i, wr_data_i,
    output bus_grnt_i, bus_rd_data_i, bus_rdy_i,
    input  ready_o, done_o, err_o, rd_data_o,
    input  bus_req_o, bus_as_o, bus_rw_o, bus_addr_o, bus_wr_data_o
  );
endinterface

// File: rtl/bus_master_if.sv
// Single-word bus master: takes one core access, arbitrates for the shared bus,
// runs the strobe/ready handshake and aborts on a slave timeout.
module bus_master_if #(
  parameter int ADDR_WIDTH     = 30,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic             clk_i,
  input logic             rst_i,
  bus_master_if_if.master bif
);

  // A one-bit counter is kept even when the timeout is disabled so the width is never zero.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACCESS
  } state_e;

  state_e                    state_q,       state_d;
  logic [CNT_W-1:0]          cnt_q,         cnt_d;
  logic                      bus_req_q,     bus_req_d;
  logic                      bus_as_q,      bus_as_d;
  logic                      bus_rw_q,      bus_rw_d;
  logic [ADDR_WIDTH-1:0]     bus_addr_q,    bus_addr_d;
  logic [DATA_BUS_WIDTH-1:0] bus_wr_data_q, bus_wr_data_d;
  logic [DATA_BUS_WIDTH-1:0] rd_data_q,     rd_data_d;
  logic                      done_q,        done_d;
  logic                      err_q,         err_d;
  logic                      timeout_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bus_req_q     <= 1'b0;
      bus_as_q      <= 1'b0;
      bus_rw_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      rd_data_q     <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_data_q     <= rd_data_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = bus_as_q;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_data_d     = rd_data_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    timeout_hit   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    unique case (state_q)
      IDLE: begin
        if (bif.req_i) begin
          bus_rw_d      = bif.rw_i;
          bus_addr_d    = bif.addr_i;
          bus_wr_data_d = bif.wr_data_i;
          bus_req_d     = 1'b1;
          state_d       = REQ;
        end
      end

      REQ: begin
        if (bif.bus_grnt_i) begin
          bus_as_d = 1'b1;
          cnt_d    = '0;
          state_d  = ACCESS;
        end
      end

      ACCESS: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (bif.bus_rdy_i) begin
          if (bus_rw_q) begin
            rd_data_d = bif.bus_rd_data_i;
          end
          done_d    = 1'b1;
          bus_req_d = 1'b0;
          bus_as_d  = 1'b0;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          rd_data_d = '0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          bus_req_d = 1'b0;
          bus_as_d  = 1'b0;
          state_d   = IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bif.ready_o       = (state_q == IDLE);
  assign bif.done_o        = done_q;
  assign bif.err_o         = err_q;
  assign bif.rd_data_o     = rd_data_q;
  assign bif.bus_req_o     = bus_req_q;
  assign bif.bus_as_o      = bus_as_q;
  assign bif.bus_rw_o      = bus_rw_q;
  assign bif.bus_addr_o    = bus_addr_q;
  assign bif.bus_wr_data_o = bus_wr_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Bench for bus_master_if: directed and random transactions, each predicted
// cycle by cycle from its grant delay and ready position.
module tb_bus_master_if;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int T  = 4;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  bus_master_if_if #(.ADDR_WIDTH(AW), .DATA_BUS_WIDTH(DW)) bif ();

  bus_master_if #(
    .ADDR_WIDTH    (AW),
    .DATA_BUS_WIDTH(DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bif  (bif)
  );

  int checks   = 0;
  int failures = 0;

  // Expected held values: read result and the latched bus request fields.
  logic [DW-1:0] exp_rd     = '0;
  logic          last_rw    = 1'b0;
  logic [AW-1:0] last_addr  = '0;
  logic [DW-1:0] last_wdata = '0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic rw, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic grnt,
                               input logic rdy, input logic [DW-1:0] rdata,
                               input logic rst);
    bif.req_i         = req;
    bif.rw_i          = rw;
    bif.addr_i        = addr;
    bif.wr_data_i     = wdata;
    bif.bus_grnt_i    = grnt;
    bif.bus_rdy_i     = rdy;
    bif.bus_rd_data_i = rdata;
    rst_i             = rst;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkState(input string tag, input logic ready, input logic req,
                            input logic as_, input logic done, input logic err);
    checkOutput({tag, ".ready"},   64'(bif.ready_o),       64'(ready));
    checkOutput({tag, ".bus_req"}, 64'(bif.bus_req_o),     64'(req));
    checkOutput({tag, ".bus_as"},  64'(bif.bus_as_o),      64'(as_));
    checkOutput({tag, ".done"},    64'(bif.done_o),        64'(done));
    checkOutput({tag, ".err"},     64'(bif.err_o),         64'(err));
    checkOutput({tag, ".rd_data"}, 64'(bif.rd_data_o),     64'(exp_rd));
    checkOutput({tag, ".bus_rw"},  64'(bif.bus_rw_o),      64'(last_rw));
    checkOutput({tag, ".bus_addr"}, 64'(bif.bus_addr_o),   64'(last_addr));
    checkOutput({tag, ".bus_wdat"}, 64'(bif.bus_wr_data_o), 64'(last_wdata));
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 1'($urandom), AW'($urandom), DW'($urandom),
                  1'($urandom), 1'($urandom), DW'($urandom), 1'b0);
    tick();
    checkState(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One access accepted in the current cycle. g = REQ cycles before grant,
  // a = ACCESS cycle index carrying ready (a >= T means the slave never answers),
  // rst_at = relative cycle in which reset is driven (0 = none).
  // Returns at the start of the done cycle (or just after the reset).
  task automatic runTxn(input string name, input logic rw, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int g, input int a,
                        input logic [DW-1:0] rval, input bit spurious,
                        input bit hold_req, input int rst_at);
    int            done_cyc;
    int            ai;
    bit            timed_out;
    logic          grnt;
    logic          rdy;
    logic [DW-1:0] rd;
    logic [DW-1:0] cap;

    timed_out = (a >= T);
    done_cyc  = timed_out ? (2 + g + T) : (3 + g + a);
    cap       = '0;

    applyStimulus(1'b1, rw, addr, wdata, 1'($urandom), 1'($urandom), DW'($urandom), 1'b0);
    tick();
    last_rw    = rw;
    last_addr  = addr;
    last_wdata = wdata;

    for (int c = 1; c <= done_cyc; c++) begin
      if (c == done_cyc) begin
        if (timed_out)  exp_rd = '0;
        else if (rw)    exp_rd = cap;
      end
      checkState($sformatf("%s.c%0d", name, c), c == done_cyc, c < done_cyc,
                 (c >= 2 + g) && (c < done_cyc), c == done_cyc,
                 (c == done_cyc) && timed_out);
      if (c == done_cyc) break;

      ai   = c - 2 - g;
      grnt = (c == 1 + g) ? 1'b1 : ((c < 1 + g) ? 1'b0 : 1'($urandom));
      rdy  = (ai < 0) ? (spurious ? 1'b1 : 1'($urandom)) : (ai == a);
      rd   = (ai == a) ? rval : DW'($urandom);
      if (ai == a) cap = rd;

      if (rst_at != 0 && c == rst_at) begin
        applyStimulus(1'b1, 1'($urandom), AW'($urandom), DW'($urandom), grnt, rdy, rd, 1'b1);
        tick();
        exp_rd     = '0;
        last_rw    = 1'b0;
        last_addr  = '0;
        last_wdata = '0;
        checkState({name, ".after_rst"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end

      applyStimulus(hold_req ? 1'b1 : 1'($urandom), 1'($urandom), AW'($urandom),
                    DW'($urandom), grnt, rdy, rd, 1'b0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    tick();
    checkState("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle("idle0");

    runTxn("rd_fast", 1'b1, AW'('h100), '0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 0);
    idleCycle("idle1");

    runTxn("wr_wait2", 1'b0, AW'('h2A5), 32'h12345678, 0, 2, DW'($urandom), 1'b0, 1'b0, 0);
    idleCycle("idle2");

    runTxn("grant_late", 1'b1, AW'('h3), '0, 5, 0, 32'hCAFEF00D, 1'b1, 1'b0, 0);
    idleCycle("idle3");

    runTxn("timeout", 1'b1, AW'('h44), '0, 1, 99, '0, 1'b0, 1'b0, 0);
    idleCycle("idle4");

    runTxn("rdy_last", 1'b1, AW'('h48), '0, 0, T - 1, 32'h55AA33CC, 1'b0, 1'b0, 0);
    idleCycle("idle5");

    runTxn("rst_mid", 1'b1, AW'('h50), '0, 0, 99, '0, 1'b0, 1'b0, 3);
    runTxn("after_rst", 1'b1, AW'('h60), '0, 0, 1, 32'h0BADC0DE, 1'b0, 1'b0, 0);
    idleCycle("idle6");

    runTxn("b2b_a", 1'b0, AW'('h70), 32'hA5A5A5A5, 1, 1, DW'($urandom), 1'b0, 1'b1, 0);
    runTxn("b2b_b", 1'b1, AW'('h74), '0, 0, 0, 32'h13579BDF, 1'b0, 1'b1, 0);
    idleCycle("idle7");

    for (int i = 0; i < 40; i++) begin
      runTxn($sformatf("rnd%0d", i), 1'($urandom), AW'($urandom), DW'($urandom),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), DW'($urandom),
             1'($urandom), 1'($urandom), 0);
      if ($urandom_range(0, 1) == 1) idleCycle($sformatf("rnd_idle%0d", i));
    end
    idleCycle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
